// File: rtl/spu_def.sv
// Shared SPU RAM request encodings, responder FSM states and CD ring base addresses.
package spu_def;

   typedef enum logic [2:0] {
      NO_SPU_READ  = 3'd0,
      REVERB_READ  = 3'd1,
      REVERB_WRITE = 3'd2,
      CD_WR        = 3'd3
   } spu_mem_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RWAIT = 2'd2
   } resp_state_e;

   localparam logic [17:0] CD_LEFT_BASE  = 18'h00000;
   localparam logic [17:0] CD_RIGHT_BASE = 18'h00200;

endpackage

// File: rtl/spu_ram_access_responder.sv
// Converts sequencer SPU RAM request codes into a req/ack memory transaction,
// returns read data within a fixed window and owns the CD capture ring pointer.
module spu_ram_access_responder
   import spu_def::*;
#(
   parameter int READ_LATENCY = 4,
   parameter int CD_BUF_WORDS = 512
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [2:0]                      i_SPUMemWRSel,
   input  logic                            i_SPUMemWRRight,
   input  logic [17:0]                     i_reverbAdr,
   input  logic [15:0]                     i_reverbWriteValue,
   input  logic [15:0]                     i_cdLeft,
   input  logic [15:0]                     i_cdRight,
   output logic                            o_memReq,
   output logic                            o_memWrite,
   output logic [17:0]                     o_memAdr,
   output logic [15:0]                     o_memWData,
   input  logic                            i_memAck,
   input  logic [15:0]                     i_memRData,
   input  logic                            i_memRValid,
   output logic [15:0]                     o_dataFromRAM,
   output logic [$clog2(CD_BUF_WORDS)-1:0] o_cdWritePtr,
   output logic                            o_lateError,
   output logic                            o_overlapError
);

   localparam int PTR_W = $clog2(CD_BUF_WORDS);

   resp_state_e      state_q, state_d;
   logic             req_q, req_d;
   logic             wr_q, wr_d;
   logic [17:0]      adr_q, adr_d;
   logic [15:0]      wdata_q, wdata_d;
   logic             cd_right_q, cd_right_d;
   logic [15:0]      rdata_q, rdata_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [2:0]       dl_cnt_q, dl_cnt_d;
   logic             late_q, late_d;
   logic             ovl_q, ovl_d;
   logic             busy;
   logic             capture;

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      wr_d       = wr_q;
      adr_d      = adr_q;
      wdata_d    = wdata_q;
      cd_right_d = cd_right_q;
      rdata_d    = rdata_q;
      ptr_d      = ptr_q;
      dl_cnt_d   = dl_cnt_q;
      late_d     = 1'b0;
      ovl_d      = 1'b0;

      busy    = (state_q != ST_IDLE);
      // A zero-wait controller may deliver data together with the ack.
      capture = i_memRValid && !wr_q &&
                ((state_q == ST_RWAIT) || (state_q == ST_ISSUE && i_memAck));

      case (state_q)
         ST_IDLE: begin
            cd_right_d = 1'b0;
            case (spu_mem_sel_e'(i_SPUMemWRSel))
               REVERB_READ: begin
                  state_d  = ST_ISSUE;
                  req_d    = 1'b1;
                  wr_d     = 1'b0;
                  adr_d    = i_reverbAdr;
                  dl_cnt_d = 3'd1;
               end
               REVERB_WRITE: begin
                  state_d = ST_ISSUE;
                  req_d   = 1'b1;
                  wr_d    = 1'b1;
                  adr_d   = i_reverbAdr;
                  wdata_d = i_reverbWriteValue;
               end
               CD_WR: begin
                  state_d    = ST_ISSUE;
                  req_d      = 1'b1;
                  wr_d       = 1'b1;
                  cd_right_d = i_SPUMemWRRight;
                  adr_d      = (i_SPUMemWRRight ? CD_RIGHT_BASE : CD_LEFT_BASE) | 18'(ptr_q);
                  wdata_d    = i_SPUMemWRRight ? i_cdRight : i_cdLeft;
               end
               default: ;
            endcase
         end
         ST_ISSUE: begin
            if (i_memAck) begin
               req_d = 1'b0;
               if (wr_q) begin
                  state_d = ST_IDLE;
                  // Ring advances once per stereo pair, after the right half lands.
                  if (cd_right_q) ptr_d = ptr_q + 1'b1;
               end else begin
                  state_d = capture ? ST_IDLE : ST_RWAIT;
               end
            end
         end
         ST_RWAIT: begin
            if (capture) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (capture) rdata_d = i_memRData;

      if (busy && !wr_q && !capture) begin
         if (dl_cnt_q == 3'(READ_LATENCY - 1)) late_d = 1'b1;
         if (dl_cnt_q < 3'(READ_LATENCY)) dl_cnt_d = dl_cnt_q + 3'd1;
      end

      if (busy && (spu_mem_sel_e'(i_SPUMemWRSel) != NO_SPU_READ)) ovl_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         wr_q       <= 1'b0;
         adr_q      <= '0;
         wdata_q    <= '0;
         cd_right_q <= 1'b0;
         rdata_q    <= '0;
         ptr_q      <= '0;
         dl_cnt_q   <= '0;
         late_q     <= 1'b0;
         ovl_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         wr_q       <= wr_d;
         adr_q      <= adr_d;
         wdata_q    <= wdata_d;
         cd_right_q <= cd_right_d;
         rdata_q    <= rdata_d;
         ptr_q      <= ptr_d;
         dl_cnt_q   <= dl_cnt_d;
         late_q     <= late_d;
         ovl_q      <= ovl_d;
      end
   end

   assign o_memReq       = req_q;
   assign o_memWrite     = wr_q;
   assign o_memAdr       = adr_q;
   assign o_memWData     = wdata_q;
   assign o_dataFromRAM  = rdata_q;
   assign o_cdWritePtr   = ptr_q;
   assign o_lateError    = late_q;
   assign o_overlapError = ovl_q;

endmodule

// File: tb/tb_spu_ram_access_responder.sv
// Directed bench: stimulus pushes expected memory requests, read captures and error pulses into
// queues; a negedge monitor pops and compares whenever the responder presents one.
module tb_spu_ram_access_responder;
   import spu_def::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sel;
   logic        right;
   logic [17:0] radr;
   logic [15:0] rwv, cdl, cdr;
   logic        req, wr, ack, rvalid;
   logic [17:0] madr;
   logic [15:0] mwd, rdata, dout;
   logic [8:0]  ptr;
   logic        late, ovl;

   spu_ram_access_responder dut (
      .i_clk(clk), .i_rst(rst), .i_SPUMemWRSel(sel), .i_SPUMemWRRight(right),
      .i_reverbAdr(radr), .i_reverbWriteValue(rwv), .i_cdLeft(cdl), .i_cdRight(cdr),
      .o_memReq(req), .o_memWrite(wr), .o_memAdr(madr), .o_memWData(mwd),
      .i_memAck(ack), .i_memRData(rdata), .i_memRValid(rvalid),
      .o_dataFromRAM(dout), .o_cdWritePtr(ptr), .o_lateError(late), .o_overlapError(ovl)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_seen = 1'b1;
   always @(posedge clk) rst_seen <= rst;

   int total = 0, bad = 0;

   typedef struct {logic w; logic [17:0] a; logic [15:0] d;} mreq_t;
   typedef struct {logic [15:0] d; int cy;} rd_t;
   typedef struct {bit is_late; int cy;} err_t;
   mreq_t mq[$];
   rd_t   rq[$];
   err_t  eq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %0h want nothing (cycle %0d)", name, act, cyc);
   endtask

   // Monitor
   logic [15:0] prev_dout = 16'h0;
   always @(negedge clk) begin
      mreq_t m;
      rd_t   r;
      err_t  e;
      if (req && ack) begin
         if (mq.size() == 0) unexp("memreq_unexpected", {13'd0, wr, madr});
         else begin
            m = mq.pop_front();
            chk("memreq_write", wr, m.w);
            chk("memreq_adr", madr, m.a);
            if (m.w) chk("memreq_wdata", mwd, m.d);
         end
      end
      if (late) begin
         if (eq.size() == 0) unexp("late_unexpected", late);
         else begin
            e = eq.pop_front();
            chk("late_kind", e.is_late, 1);
            chk("late_cycle", cyc, e.cy);
         end
      end
      if (ovl) begin
         if (eq.size() == 0) unexp("overlap_unexpected", ovl);
         else begin
            e = eq.pop_front();
            chk("overlap_kind", e.is_late, 0);
            chk("overlap_cycle", cyc, e.cy);
         end
      end
      if (!rst_seen && dout !== prev_dout) begin
         if (rq.size() == 0) unexp("rdata_unexpected", dout);
         else begin
            r = rq.pop_front();
            chk("rdata_value", dout, r.d);
            chk("rdata_cycle", cyc, r.cy);
         end
      end
      prev_dout = dout;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int T;

   initial begin
      rst = 1'b1; sel = NO_SPU_READ; right = 1'b0; radr = '0; rwv = '0;
      cdl = '0; cdr = '0; ack = 1'b0; rvalid = 1'b0; rdata = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_req", req, 0);
      chk("rst_write", wr, 0);
      chk("rst_adr", madr, 0);
      chk("rst_wdata", mwd, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ptr", ptr, 0);
      chk("rst_errs", {late, ovl}, 0);
      tick();

      // Nominal read: ack T+1, data T+2
      T = cyc; sel = REVERB_READ; radr = 18'h12345;
      mq.push_back('{1'b0, 18'h12345, 16'h0});
      tick(); sel = NO_SPU_READ; ack = 1'b1;
      chk("t1_req_T1", req, 1);
      chk("t1_adr", madr, 18'h12345);
      chk("t1_write", wr, 0);
      tick(); ack = 1'b0; rvalid = 1'b1; rdata = 16'hBEEF;
      rq.push_back('{16'hBEEF, T + 3});
      chk("t1_req_T2", req, 0);
      tick(); rvalid = 1'b0;
      chk("t1_dout", dout, 16'hBEEF);
      repeat (3) tick();

      // Write with ack delayed to the third request cycle
      T = cyc; sel = REVERB_WRITE; radr = 18'h00100; rwv = 16'hA5A5;
      mq.push_back('{1'b1, 18'h00100, 16'hA5A5});
      tick(); sel = NO_SPU_READ; rwv = 16'hFFFF; radr = 18'h3FFFF;
      for (int i = 1; i <= 3; i++) begin
         chk("t2_req_held", req, 1);
         chk("t2_write", wr, 1);
         chk("t2_adr", madr, 18'h00100);
         chk("t2_wdata", mwd, 16'hA5A5);
         if (i == 3) ack = 1'b1;
         tick();
      end
      ack = 1'b0;
      chk("t2_req_drop", req, 0);
      repeat (2) tick();

      // Walk the CD ring up to 511 with right-channel writes
      for (int k = 0; k < 511; k++) begin
         sel = CD_WR; right = 1'b1; cdr = 16'(k + 16'h4000); cdl = 16'h0BAD;
         mq.push_back('{1'b1, 18'h00200 | 18'(k), 16'(k + 16'h4000)});
         tick(); sel = NO_SPU_READ; ack = 1'b1;
         tick(); ack = 1'b0;
         repeat (2) tick();
      end
      chk("t3_ptr_511", ptr, 9'd511);
      sel = CD_WR; right = 1'b0; cdl = 16'h1111; cdr = 16'h2222;
      mq.push_back('{1'b1, 18'h001FF, 16'h1111});
      tick(); sel = NO_SPU_READ; ack = 1'b1;
      tick(); ack = 1'b0;
      chk("t3_ptr_after_left", ptr, 9'd511);
      repeat (2) tick();
      sel = CD_WR; right = 1'b1;
      mq.push_back('{1'b1, 18'h003FF, 16'h2222});
      tick(); sel = NO_SPU_READ; ack = 1'b1;
      tick(); ack = 1'b0;
      chk("t3_ptr_wrap", ptr, 9'd0);
      repeat (2) tick();

      // Late read: data arrives at T+5
      T = cyc; sel = REVERB_READ; radr = 18'h00ABC;
      mq.push_back('{1'b0, 18'h00ABC, 16'h0});
      eq.push_back('{1'b1, T + 4});
      tick(); sel = NO_SPU_READ; ack = 1'b1;
      tick(); ack = 1'b0;
      tick();
      chk("t4_late_T3", late, 0);
      tick();
      chk("t4_late_T4", late, 1);
      chk("t4_dout_T4", dout, 16'hBEEF);
      tick(); rvalid = 1'b1; rdata = 16'h1234;
      rq.push_back('{16'h1234, T + 6});
      tick(); rvalid = 1'b0;
      chk("t4_dout_T6", dout, 16'h1234);
      repeat (2) tick();

      // Overlapping request while in ISSUE is dropped
      T = cyc; sel = REVERB_READ; radr = 18'h22222;
      mq.push_back('{1'b0, 18'h22222, 16'h0});
      tick(); radr = 18'h33333;
      eq.push_back('{1'b0, T + 2});
      tick(); sel = NO_SPU_READ; ack = 1'b1;
      chk("t5_adr_kept", madr, 18'h22222);
      tick(); ack = 1'b0; rvalid = 1'b1; rdata = 16'h5678;
      rq.push_back('{16'h5678, T + 4});
      tick(); rvalid = 1'b0;
      repeat (3) tick();

      // Reset during RWAIT, then a stray RValid
      sel = REVERB_READ; radr = 18'h00444;
      mq.push_back('{1'b0, 18'h00444, 16'h0});
      tick(); sel = NO_SPU_READ; ack = 1'b1;
      tick(); ack = 1'b0; rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t6_req_after_rst", req, 0);
      chk("t6_dout_after_rst", dout, 0);
      rvalid = 1'b1; rdata = 16'hDEAD;
      tick(); rvalid = 1'b0;
      chk("t6_dout_stray", dout, 0);
      chk("t6_req_stray", req, 0);
      repeat (2) tick();
      sel = REVERB_WRITE; radr = 18'h00777; rwv = 16'h0F0F;
      mq.push_back('{1'b1, 18'h00777, 16'h0F0F});
      tick(); sel = NO_SPU_READ; ack = 1'b1;
      chk("t6_idle_accepts", req, 1);
      tick(); ack = 1'b0;
      repeat (2) tick();

      // Zero-wait controller: ack and data together in ISSUE
      T = cyc; sel = REVERB_READ; radr = 18'h00999;
      mq.push_back('{1'b0, 18'h00999, 16'h0});
      tick(); sel = NO_SPU_READ; ack = 1'b1; rvalid = 1'b1; rdata = 16'h7E57;
      rq.push_back('{16'h7E57, T + 2});
      tick(); ack = 1'b0; rvalid = 1'b0;
      chk("t7_req_done", req, 0);
      repeat (6) tick();

      chk("end_memreq_queue", mq.size(), 0);
      chk("end_rdata_queue", rq.size(), 0);
      chk("end_err_queue", eq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
